tcp_checksum_arbiter: RTL

//  Shares one 512-bit TCP checksum engine between NUM_PORTS AXI-Stream packet sources.

---
 rtl/tcp_checksum_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/tcp_checksum_arbiter.sv
// Packet-granular round-robin arbiter sharing one 512-bit TCP checksum engine between
// NUM_PORTS AXI-Stream sources; results are routed back by an in-order tag FIFO.
// Optional per-port grant counters are built when CKSUM_ARB_STATS_EN is defined.
//
// Handshake rule on every stream: a beat transfers on a rising clk edge where
// TVALID and TREADY are both high; once TVALID is raised the sender holds the beat
// stable until it transfers.
module tcp_checksum_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int TAG_DEPTH = 8,
    localparam int IDX_W = $clog2(NUM_PORTS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_PORTS*512-1:0] S_AXIS_TDATA,
    input  logic [NUM_PORTS*64-1:0]  S_AXIS_TKEEP,
    input  logic [NUM_PORTS-1:0]     S_AXIS_TVALID,
    input  logic [NUM_PORTS-1:0]     S_AXIS_TLAST,
    output logic [NUM_PORTS-1:0]     S_AXIS_TREADY,
    output logic [511:0]             M_AXIS_TDATA,
    output logic [63:0]              M_AXIS_TKEEP,
    output logic                     M_AXIS_TVALID,
    output logic                     M_AXIS_TLAST,
    input  logic                     M_AXIS_TREADY,
    input  logic [15:0]              S_RES_TDATA,
    input  logic                     S_RES_TVALID,
    output logic                     S_RES_TREADY,
    output logic [15:0]              M_RES_TDATA,
    output logic [IDX_W-1:0]         M_RES_TDEST,
    output logic                     M_RES_TVALID,
    input  logic                     M_RES_TREADY,
    output logic                     ERR_ORPHAN,
    output logic [NUM_PORTS*32-1:0]  PKT_CNT
);

    localparam int PTR_W = $clog2(TAG_DEPTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] grant_q, last_grant_q, next_port;
    logic             any_valid;
    logic             start_grant;
    logic             beat_done;

    logic [IDX_W-1:0] tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   tag_cnt_q;
    logic             fifo_full, fifo_empty;
    logic             res_hs, pop;

    assign fifo_full  = (tag_cnt_q == (PTR_W+1)'(TAG_DEPTH));
    assign fifo_empty = (tag_cnt_q == '0);

    // Round-robin scan: the first valid port after last_grant_q (with wrap) wins.
    always_comb begin
        next_port = last_grant_q;
        any_valid = 1'b0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (!any_valid && S_AXIS_TVALID[p] &&
                    (p == (int'(last_grant_q) + i) % NUM_PORTS)) begin
                    next_port = IDX_W'(p);
                    any_valid = 1'b1;
                end
            end
        end
    end

    assign start_grant = (state_q == IDLE) && any_valid && !fifo_full;
    assign beat_done   = (state_q == XFER) && M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST;

    always_comb begin
        state_d       = state_q;
        M_AXIS_TDATA  = '0;
        M_AXIS_TKEEP  = '0;
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TLAST  = 1'b0;
        S_AXIS_TREADY = '0;
        case (state_q)
            IDLE: begin
                if (start_grant) state_d = XFER;
            end
            XFER: begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (grant_q == IDX_W'(p)) begin
                        M_AXIS_TDATA     = S_AXIS_TDATA[p*512 +: 512];
                        M_AXIS_TKEEP     = S_AXIS_TKEEP[p*64 +: 64];
                        M_AXIS_TVALID    = S_AXIS_TVALID[p];
                        M_AXIS_TLAST     = S_AXIS_TLAST[p];
                        S_AXIS_TREADY[p] = M_AXIS_TREADY;
                    end
                end
                if (beat_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_PORTS - 1);
        end else begin
            state_q <= state_d;
            if (start_grant) grant_q <= next_port;
            if (beat_done) last_grant_q <= grant_q;
        end
    end

    // Tag FIFO: one entry per granted packet, popped as its checksum comes back.
    assign S_RES_TREADY = !M_RES_TVALID || M_RES_TREADY;
    assign res_hs       = S_RES_TVALID && S_RES_TREADY;
    assign pop          = res_hs && !fifo_empty;

    always_ff @(posedge clk) begin
        if (start_grant) tag_mem[wr_ptr_q] <= next_port;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            tag_cnt_q <= '0;
        end else begin
            if (start_grant) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({start_grant, pop})
                2'b10:   tag_cnt_q <= tag_cnt_q + 1'b1;
                2'b01:   tag_cnt_q <= tag_cnt_q - 1'b1;
                default: tag_cnt_q <= tag_cnt_q;
            endcase
        end
    end

    // Result output register; a result with no outstanding tag is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            M_RES_TVALID <= 1'b0;
            M_RES_TDATA  <= '0;
            M_RES_TDEST  <= '0;
            ERR_ORPHAN   <= 1'b0;
        end else begin
            if (M_RES_TREADY) M_RES_TVALID <= 1'b0;
            if (pop) begin
                M_RES_TDATA  <= S_RES_TDATA;
                M_RES_TDEST  <= tag_mem[rd_ptr_q];
                M_RES_TVALID <= 1'b1;
            end
            if (res_hs && fifo_empty) ERR_ORPHAN <= 1'b1;
        end
    end

`ifdef CKSUM_ARB_STATS_EN
    logic [31:0] pkt_cnt_q [NUM_PORTS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PORTS; p++) pkt_cnt_q[p] <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (start_grant && next_port == IDX_W'(p)) pkt_cnt_q[p] <= pkt_cnt_q[p] + 32'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
        assign PKT_CNT[g*32 +: 32] = pkt_cnt_q[g];
    end
`else
    assign PKT_CNT = '0;
`endif

endmodule
